// File: rtl/mult_div_seq_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Op encodings, external ALU codes, FSM states and iteration count.
package mult_div_seq_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  localparam int ITER = 32;

  function automatic logic is_div(op_e o);
    return o[1];
  endfunction

  function automatic logic is_signed(op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/mult_div_seq_if.sv
// Request/result bundle between a requester and mult_div_seq.
// master issues start/op/operands; slave returns status and results.
interface mult_div_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_seq.sv
// Sequential 32x32 multiply / 32/32 divide borrowing a shared ALU.
// Shift-add multiply and restoring divide, 35 cycles start to done.
module mult_div_seq
  import mult_div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mult_div_seq_if.slave bus,
  output logic        alu_own,
  output logic [3:0]  alu_ctr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_f,
  input  logic        alu_cf
);

  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] p_q, p_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        rsgn_q, rsgn_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [32:0] s;
  logic [63:0] prod;

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      rsgn_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      rsgn_q  <= rsgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next state, datapath updates and ALU drive.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    rsgn_d  = rsgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    alu_own = 1'b0;
    alu_ctr = ALU_NOP;
    alu_a   = '0;
    alu_b   = '0;
    s       = '0;
    prod    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_PREP;
          op_d    = op_e'(bus.op);
          a_d     = bus.rs_val;
          b_d     = bus.rt_val;
        end
      end
      S_PREP: begin
        sgn_d  = is_signed(op_q) & (a_q[31] ^ b_q[31]);
        rsgn_d = is_signed(op_q) & a_q[31];
        if (is_signed(op_q) && a_q[31]) a_d = -a_q;
        if (is_signed(op_q) && b_q[31]) b_d = -b_q;
        p_d     = '0;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        alu_own = 1'b1;
        if (is_div(op_q)) begin
          s       = {p_q, a_q[31]};
          alu_ctr = ALU_SUB;
          alu_a   = s[31:0];
          alu_b   = b_q;
          if (s[32] || !alu_cf) begin
            p_d = alu_f;
            a_d = {a_q[30:0], 1'b1};
          end else begin
            p_d = s[31:0];
            a_d = {a_q[30:0], 1'b0};
          end
        end else begin
          alu_ctr = ALU_ADD;
          alu_a   = p_q;
          alu_b   = a_q[0] ? b_q : '0;
          p_d     = {alu_cf, alu_f[31:1]};
          a_d     = {alu_f[0], a_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div(op_q)) begin
          lo_d = sgn_q  ? -a_q : a_q;
          hi_d = rsgn_q ? -p_q : p_q;
        end else begin
          prod = {p_q, a_q};
          if (sgn_q) prod = -prod;
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq with an external ALU model.
// Directed vectors, corner sequences and random ops vs arithmetic model.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_own;
  logic [3:0]  alu_ctr;
  logic [31:0] alu_a, alu_b, alu_f;
  logic        alu_cf;

  int errs = 0;
  int checks = 0;

  mult_div_seq_if md_if ();

  mult_div_seq dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (md_if.slave),
    .alu_own (alu_own),
    .alu_ctr (alu_ctr),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_f   (alu_f),
    .alu_cf  (alu_cf)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_f  = '0;
    alu_cf = 1'b0;
    case (alu_ctr)
      4'b0010: {alu_cf, alu_f} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0110: {alu_cf, alu_f} = {1'b0, alu_a} - {1'b0, alu_b};
      default: ;
    endcase
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_model(logic [1:0] o,
                                            logic [31:0] a,
                                            logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    logic        sg;
    longint      sp;
    if (!o[1]) begin
      if (o[0]) return {32'b0, a} * {32'b0, b};
      sp = longint'($signed(a)) * longint'($signed(b));
      return sp;
    end
    sg = !o[0];
    ua = (sg && a[31]) ? 32'(0 - a) : a;
    ub = (sg && b[31]) ? 32'(0 - b) : b;
    if (ub == 0) begin
      q = 32'hFFFF_FFFF;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (sg && (a[31] ^ b[31])) q = 32'(0 - q);
    if (sg && a[31]) r = 32'(0 - r);
    return {r, q};
  endfunction

  // Called at a negedge; issues one op and watches 40 cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int inj,
                        output logic [31:0] h, output logic [31:0] l,
                        output int lat, output int npulse,
                        output int nown, output logic hold_ok);
    md_if.start  = 1'b1;
    md_if.op     = o;
    md_if.rs_val = a;
    md_if.rt_val = b;
    @(posedge clk);
    lat = -1;
    npulse = 0;
    nown = 0;
    h = '0;
    l = '0;
    hold_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      md_if.start = (n == inj);
      if (n == inj) begin
        md_if.op     = ~o;
        md_if.rs_val = ~a;
        md_if.rt_val = b + 32'd1;
      end
      if (md_if.done) begin
        npulse++;
        if (lat < 0) begin
          lat = n;
          h = md_if.hi;
          l = md_if.lo;
        end
      end else if (lat > 0 &&
                   (md_if.hi !== h || md_if.lo !== l)) begin
        hold_ok = 1'b0;
      end
      if (alu_own) nown++;
    end
  endtask

  logic [31:0] h, l;
  logic [63:0] e;
  int          lat, np, nown;
  logic        hold;
  logic [1:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    tbl[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007,
               32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002,
               32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000};
    tbl[4] = '{2'b11, 32'h0000_0007, 32'h0000_0000,
               32'h0000_0007, 32'hFFFF_FFFF};
    tbl[5] = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14};
    tbl[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000};
    tbl[7] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000,
               32'hFFFF_FFF9, 32'h0000_0001};
    tbl[8] = '{2'b01, 32'h0000_0000, 32'h0001_2345,
               32'h0000_0000, 32'h0000_0000};
    tbl[9] = '{2'b00, 32'h0001_0000, 32'hFFFF_0000,
               32'hFFFF_FFFF, 32'h0000_0000};

    md_if.start  = 1'b0;
    md_if.op     = 2'b00;
    md_if.rs_val = '0;
    md_if.rt_val = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", md_if.busy, 0);
    chk("rst done", md_if.done, 0);
    chk("rst hi", md_if.hi, 0);
    chk("rst lo", md_if.lo, 0);
    chk("rst alu_own", alu_own, 0);
    chk("rst alu_ctr", alu_ctr, 0);
    chk("rst alu_ab", {alu_a, alu_b}, 0);

    md_if.start = 1'b1;
    @(negedge clk);
    chk("rst over start", md_if.busy, 0);
    md_if.start = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, h, l, lat, np, nown, hold);
      chk($sformatf("tbl%0d hi", i), h, tbl[i].eh);
      chk($sformatf("tbl%0d lo", i), l, tbl[i].el);
      chk($sformatf("tbl%0d latency", i), lat, 35);
      chk($sformatf("tbl%0d pulses", i), np, 1);
      chk($sformatf("tbl%0d own cycles", i), nown, 32);
      chk($sformatf("tbl%0d hold", i), hold, 1);
    end

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, h, l, lat, np, nown,
           hold);
    chk("ignore start hi", h, 32'hFFFF_FFFE);
    chk("ignore start lo", l, 32'h0000_0001);
    chk("ignore start pulses", np, 1);
    chk("ignore start latency", lat, 35);
    chk("ignore start idle", md_if.busy, 0);

    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, h, l, lat, np, nown,
           hold);
    md_if.start  = 1'b1;
    md_if.op     = 2'b11;
    md_if.rs_val = 32'd1000;
    md_if.rt_val = 32'd3;
    @(posedge clk);
    @(negedge clk);
    md_if.start = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid run own", alu_own, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst busy", md_if.busy, 0);
    chk("mid rst done", md_if.done, 0);
    chk("mid rst hilo", {md_if.hi, md_if.lo}, 0);
    chk("mid rst alu_own", alu_own, 0);
    chk("mid rst alu bus", {alu_ctr, alu_a, alu_b}, 0);
    rst = 1'b0;
    run_op(2'b11, 32'd100, 32'd7, 0, h, l, lat, np, nown, hold);
    chk("post rst lo", l, 32'd14);
    chk("post rst hi", h, 32'd2);
    chk("post rst latency", lat, 35);

    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      e = ref_model(ro, ra, rb);
      run_op(ro, ra, rb, 0, h, l, lat, np, nown, hold);
      chk($sformatf("rnd%0d op%0d %h,%h", i, ro, ra, rb), {h, l}, e);
      chk($sformatf("rnd%0d latency", i), lat, 35);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
